// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM states and BCD digit constants for the BCD-to-binary converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX_DIGIT = 9;
  function automatic int digit_count(input int n);
    return n / BCD_DIGIT_W;
  endfunction
endpackage

// File: rtl/bcd_digit_mac.sv
// bcd_digit_mac: combinational acc*10 + digit using shift-add only
module bcd_digit_mac #(
  parameter int N = 16
) (
  input  logic [N-1:0] acc,
  input  logic [3:0]   digit,
  output logic [N-1:0] sum
);
  assign sum = (acc << 3) + (acc << 1) + N'(digit);
endmodule

// File: rtl/bcd2binary.sv
// bcd2binary: sequential packed-BCD to binary converter, one digit per clock MSD first (BCD2BINARY_CHECK_EN enables invalid-digit detection)
module bcd2binary
  import bcd_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] text,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] number,
  output logic         error
);
  localparam int DIGITS = digit_count(N);
  localparam int CW = $clog2(DIGITS + 1);
  state_t state, next;
  logic [N-1:0] shreg, acc, mac;
  logic [CW-1:0] cnt;
  logic [W-1:0] digit;
  logic last, accept;
  assign digit = shreg[N-1 -: W];
  assign last = cnt == CW'(DIGITS - 1);
  assign accept = state == IDLE && start;
  bcd_digit_mac #(.N(N)) u_mac (.acc(acc), .digit(digit), .sum(mac));
  // next-state and status outputs
  always_comb begin
    next = state == IDLE ? (start ? CONVERT : IDLE) : state == CONVERT ? (last ? DONE : CONVERT) : IDLE;
    busy = state == CONVERT;
    done = state == DONE;
  end
`ifdef BCD2BINARY_CHECK_EN
  logic flag, bad;
  assign bad = digit > W'(BCD_MAX_DIGIT);
  // sticky invalid-digit flag; result is zeroed when any digit was invalid
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      shreg <= '0;
      cnt <= '0;
      number <= '0;
      error <= 1'b0;
      flag <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        shreg <= text;
        acc <= '0;
        cnt <= '0;
        flag <= 1'b0;
      end else if (state == CONVERT) begin
        acc <= mac;
        shreg <= shreg << W;
        cnt <= cnt + CW'(1);
        flag <= flag | bad;
        if (last) begin
          number <= (flag | bad) ? '0 : mac;
          error <= flag | bad;
        end
      end
    end
  end
`else
  assign error = 1'b0;
  // digit accumulation; invalid nibbles enter the arithmetic as raw values
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      shreg <= '0;
      cnt <= '0;
      number <= '0;
    end else begin
      state <= next;
      if (accept) begin
        shreg <= text;
        acc <= '0;
        cnt <= '0;
      end else if (state == CONVERT) begin
        acc <= mac;
        shreg <= shreg << W;
        cnt <= cnt + CW'(1);
        if (last) number <= mac;
      end
    end
  end
`endif
endmodule

// File: tb/tb_bcd2binary.sv
// tb_bcd2binary: scoreboard bench for bcd2binary with directed vectors and a full 0..9999 sweep
module tb_bcd2binary;
  localparam int N = 16;
  logic clk = 1'b0;
  logic reset, start;
  logic [N-1:0] text;
  logic busy, done, error;
  logic [N-1:0] number;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_done = 0;
  int last_done = -1;
  bit sweep = 1'b0;
  logic [N:0] q[$];
  bcd2binary #(.N(N), .W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .text(text),
    .busy(busy), .done(done), .number(number), .error(error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask
  function automatic logic [N-1:0] to_bcd(input int v);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N / 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  // monitor: pop expected result on every done pulse
  always @(negedge clk) begin
    if (done) begin
      logic [N:0] e;
      n_done++;
      if (sweep && last_done >= 0) chk("done_spacing", cyc - last_done, 6);
      last_done = cyc;
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("number", 32'(number), 32'(e[N-1:0]));
        chk("error", 32'(error), 32'(e[N]));
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic conv(input logic [N-1:0] t, input logic [N-1:0] exp_num, input logic exp_err);
    bit seen;
    q.push_back({exp_err, exp_num});
    text = t;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) chk("done_timeout", 0, 1);
    tick();
  endtask
  initial begin
    int d0;
    reset = 1'b1;
    start = 1'b0;
    text = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_number", 32'(number), 0);
    chk("reset_error", 32'(error), 0);
    tick();
    q.push_back({1'b0, 16'h0000});
    text = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", i), 32'(busy), i <= 4 ? 1 : 0);
      chk($sformatf("done_c%0d", i), 32'(done), i == 5 ? 1 : 0);
      tick();
    end
    conv(16'h9999, 16'h270F, 1'b0);
    conv(16'h0102, 16'h0066, 1'b0);
    d0 = n_done;
    q.push_back({1'b0, 16'h04D2});
    text = 16'h1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    text = 16'h5678;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("ignored_start_dones", 32'(n_done - d0), 1);
    chk("ignored_start_idle", 32'(busy), 0);
    d0 = n_done;
    text = 16'h5555;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    text = 16'h0042;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_number", 32'(number), 0);
    chk("abort_error", 32'(error), 0);
    repeat (8) tick();
    chk("abort_no_done", 32'(n_done - d0), 0);
    conv(16'h0042, 16'd42, 1'b0);
    last_done = -1;
    sweep = 1'b1;
    d0 = n_done;
    start = 1'b1;
    for (int v = 0; v <= 9999; v++) begin
      text = to_bcd(v);
      q.push_back({1'b0, 16'(v)});
      tick();
      repeat (5) @(posedge clk);
    end
    start = 1'b0;
    #1;
    repeat (8) tick();
    sweep = 1'b0;
    chk("sweep_dones", 32'(n_done - d0), 10000);
`ifdef BCD2BINARY_CHECK_EN
    conv(16'h12A4, 16'h0000, 1'b1);
`else
    conv(16'h12A4, 16'd1304, 1'b0);
`endif
    repeat (3) tick();
    chk("queue_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd2binary.md
# bcd2binary

Sequential packed-BCD to binary converter: the decode direction of the team's binary-to-BCD path. It accepts an N-bit packed-BCD word (N/4 digits, most significant digit in the top nibble) on a start strobe. It accumulates one digit per clock (acc = acc*10 + digit, MSD first) and presents the binary value with a one-cycle done pulse. It sits behind keypad/text entry logic that hands decimal digits to arithmetic datapaths.

## Interface
Parameters:
- N, 16: width of BCD input and binary result; must be a multiple of 4.
- W, 4: digit width in bits; fixed at 4.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- text  input  N  packed BCD word; captured on accepted start.
- busy  output  1  high while converting.
- done  output  1  one-cycle pulse; result valid this cycle.
- number  output  N  binary result; held until the next done.
- error  output  1  invalid digit seen; qualified by done.

## Operation
- States: IDLE, CONVERT, DONE.
- IDLE, start=1: capture text into shift register, acc=0, digit count=0 -> CONVERT. IDLE, start=0: stay.
- CONVERT, each cycle:
  - acc = acc*10 + top nibble.
  - Shift register left by 4.
  - count++.
  - After the N/4-th digit -> DONE; number (and error) register on that edge.
- DONE: done=1 for exactly one cycle -> IDLE unconditionally.
- start in CONVERT or DONE: ignored, not queued; text changes after capture have no effect.
- Arithmetic:
  - acc*10 computed as (acc<<3)+(acc<<1), N bits wide, no truncation.
  - Max legal 10^(N/4)-1 < 2^N; max with invalid digits 15*(10^(N/4)-1)/9 < 2^N, so overflow is impossible.
- Leading zero digits are processed normally; 0 yields 0.

## Timing
- Reset values: busy=0, done=0, number=0, error=0, state IDLE, acc=0.
- start high at edge k -> busy high cycles k+1..k+N/4 -> done high cycle k+N/4+1, number valid from that cycle.
- For N=16: done 5 cycles after the start edge.
- Minimum start-to-start spacing N/4+2 cycles; start may be held high continuously and is re-accepted in the IDLE cycle after DONE.
- reset mid-conversion:
  - Abandons the operation; next cycle is IDLE with all outputs at reset values.
  - No done pulse for the aborted request.
- reset and start in the same cycle: reset wins; start is dropped.

## Configuration
- BCD2BINARY_CHECK_EN defined:
  - Any nibble > 9 seen during CONVERT sets a sticky flag, cleared on accepted start.
  - At DONE, error=flag, and number is forced to 0 when the flag is set.
- Undefined:
  - error tied to 0.
  - Invalid nibbles enter the arithmetic as their raw value (0xA=10 ... 0xF=15).

## Structure
- Package bcd_pkg:
  - State enum {IDLE, CONVERT, DONE}.
  - BCD_DIGIT_W=4, BCD_MAX_DIGIT=9.
  - Helper constant for digit count N/BCD_DIGIT_W.
- Sub-module bcd_digit_mac: combinational acc*10+digit, N-bit, shift-add, no multiplier; instantiated once.
- Top holds FSM, shift register, counter, result/error registers.

## Test plan
- Reset then text=16'h0000, start -> done at cycle 5, number=0, error=0; busy high exactly 4 cycles.
- text=16'h9999 -> number=16'h270F (9999); text=16'h0102 -> 16'h0066 (102).
- Sweep text = BCD of 0..9999 via back-to-back starts with start held high -> each number equals the decimal value; one done per conversion; spacing 6 cycles.
- Pulse start again at cycles 2 and 5 of a conversion -> ignored, single done, result of the first text only.
- Assert reset at cycle 3 of a conversion -> busy/done/number=0 next cycle; no done; fresh start on 16'h0042 yields 42.
- text=16'h12A4: with BCD2BINARY_CHECK_EN -> error=1, number=0; without -> error=0, number=1304.
